// File: rtl/multicycle_ctrl.sv
// Multicycle LEGv8 control FSM: sequences FETCH/DECODE/EXEC/MEM/WB and counts retired instructions.
// Build option ILLEGAL_TRAP_EN: unrecognised opcodes enter an absorbing TRAP state instead of acting as a NOP.
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [10:0]      Op,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             Reg2Loc,
  output logic             ALUSrc,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             Branch,
  output logic [1:0]       ALUOp,
  output logic             PCWrite,
  output logic             IRWrite,
  output logic             Exc,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_retired
);

  // state  | meaning
  // FETCH  | load IR, PC <= PC+4
  // DECODE | classify Op
  // EXEC_R | R-type ALU operation
  // WB_R   | R-type register write, retire
  // ADDR   | LDUR/STUR address computation
  // MEM_RD | load access, waits for mem_ready
  // WB_LD  | load register write, retire
  // MEM_WR | store access, waits for mem_ready, retires
  // BRANCH | CBZ, PC <= target when Zero, retire
  // TRAP   | illegal opcode, held until reset
  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    EXEC_R = 4'd2,
    WB_R   = 4'd3,
    ADDR   = 4'd4,
    MEM_RD = 4'd5,
    WB_LD  = 4'd6,
    MEM_WR = 4'd7,
    BRANCH = 4'd8,
    TRAP   = 4'd9
  } state_t;

`ifdef ILLEGAL_TRAP_EN
  localparam state_t ILL_NEXT = TRAP;
`else
  localparam state_t ILL_NEXT = FETCH;
`endif

  state_t     st, nxt;
  logic       is_ld, nxt_ld;
  logic       retire;
  logic       op_ld, op_st, op_r, op_cbz;
  logic [8:0] flags_q;
  logic       fetch_q;

  always_comb begin
    op_ld  = 1'b0;
    op_st  = 1'b0;
    op_r   = 1'b0;
    op_cbz = 1'b0;
    casez (Op)
      11'b111_1100_0010: op_ld  = 1'b1;
      11'b111_1100_0000: op_st  = 1'b1;
      11'b100_0101_1000,
      11'b110_0101_1000,
      11'b100_0101_0000,
      11'b101_0101_0000: op_r   = 1'b1;
      11'b101_1010_0???: op_cbz = 1'b1;
      default: ;
    endcase
  end

  // Load/store choice is captured in DECODE so ADDR and the memory states need not re-decode Op.
  assign nxt_ld = (st == DECODE) ? op_ld : is_ld;

  always_comb begin
    nxt    = st;
    retire = 1'b0;
    case (st)
      FETCH:  nxt = DECODE;
      DECODE: begin
        if (op_ld || op_st) nxt = ADDR;
        else if (op_r)      nxt = EXEC_R;
        else if (op_cbz)    nxt = BRANCH;
        else                nxt = ILL_NEXT;
      end
      EXEC_R: nxt = WB_R;
      WB_R:   begin nxt = FETCH; retire = 1'b1; end
      ADDR:   nxt = is_ld ? MEM_RD : MEM_WR;
      MEM_RD: if (mem_ready) nxt = WB_LD;
      WB_LD:  begin nxt = FETCH; retire = 1'b1; end
      MEM_WR: if (mem_ready) begin nxt = FETCH; retire = 1'b1; end
      BRANCH: begin nxt = FETCH; retire = 1'b1; end
      TRAP:   nxt = TRAP;
      default: nxt = FETCH;
    endcase
  end

  // {Reg2Loc,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,ALUOp}
  function automatic logic [8:0] flags_of(input state_t s, input logic ld);
    case (s)
      EXEC_R:  return 9'b000_000_010;
      WB_R:    return 9'b000_100_010;
      ADDR:    return ld ? 9'b011_000_000 : 9'b110_000_000;
      MEM_RD:  return 9'b011_010_000;
      WB_LD:   return 9'b011_110_000;
      MEM_WR:  return 9'b110_001_000;
      BRANCH:  return 9'b100_000_101;
      default: return 9'b000_000_000;
    endcase
  endfunction

  // Outputs are registered from the next state, so they always match the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      st            <= FETCH;
      is_ld         <= 1'b0;
      flags_q       <= 9'b0;
      fetch_q       <= 1'b1;
      instr_retired <= '0;
    end else begin
      st      <= nxt;
      is_ld   <= nxt_ld;
      flags_q <= flags_of(nxt, nxt_ld);
      fetch_q <= (nxt == FETCH);
      if (retire) instr_retired <= instr_retired + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign {Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp} = flags_q;
  assign IRWrite = fetch_q;
  assign PCWrite = fetch_q | ((st == BRANCH) & Zero);
  assign state   = st;

`ifdef ILLEGAL_TRAP_EN
  assign Exc = (st == TRAP);
`else
  assign Exc = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus pushes hand-computed per-cycle expectations, a monitor pops one per cycle.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] Op = 11'b0;
  logic        Zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch;
  logic [1:0]  ALUOp;
  logic        PCWrite, IRWrite, Exc;
  logic [3:0]  state;
  logic [3:0]  instr_retired;

  multicycle_ctrl #(.CNT_W(4)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Zero(Zero), .mem_ready(mem_ready),
    .Reg2Loc(Reg2Loc), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch), .ALUOp(ALUOp),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .Exc(Exc), .state(state),
    .instr_retired(instr_retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] st;
    logic [8:0] fl;
    logic       irw;
    logic       pcw;
    logic       exc;
    logic [3:0] cnt;
  } exp_t;

  exp_t       q[$];
  int         n_vec = 0;
  int         n_err = 0;
  logic [3:0] exp_cnt = 4'd0;

  localparam logic [10:0] OP_ADD  = 11'b100_0101_1000;
  localparam logic [10:0] OP_SUB  = 11'b110_0101_1000;
  localparam logic [10:0] OP_AND  = 11'b100_0101_0000;
  localparam logic [10:0] OP_ORR  = 11'b101_0101_0000;
  localparam logic [10:0] OP_LDUR = 11'b111_1100_0010;
  localparam logic [10:0] OP_STUR = 11'b111_1100_0000;

  task automatic push(input logic [3:0] s, input logic [8:0] f, input logic irw, input logic pcw, input logic exc);
    exp_t e;
    e.st = s; e.fl = f; e.irw = irw; e.pcw = pcw; e.exc = exc; e.cnt = exp_cnt;
    q.push_back(e);
  endtask

  task automatic push_fetch();
    push(4'd0, 9'b0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("state", 16'(state), 16'(e.st));
      chk("flags", 16'({Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp}), 16'(e.fl));
      chk("irw_pcw_exc", 16'({IRWrite, PCWrite, Exc}), 16'({e.irw, e.pcw, e.exc}));
      chk("instr_retired", 16'(instr_retired), 16'(e.cnt));
    end
  end

  // Each task starts at a falling edge inside FETCH and ends at a falling edge inside the next FETCH.
  task automatic run_r(input logic [10:0] op);
    Op = op; mem_ready = 1'b0;
    push(4'd1, 9'b0, 1'b0, 1'b0, 1'b0);
    push(4'd2, 9'b000_000_010, 1'b0, 1'b0, 1'b0);
    push(4'd3, 9'b000_100_010, 1'b0, 1'b0, 1'b0);
    exp_cnt = exp_cnt + 4'd1;
    push_fetch();
    repeat (4) @(negedge clk);
  endtask

  task automatic run_ldur(input int stall);
    Op = OP_LDUR; mem_ready = 1'b0;
    push(4'd1, 9'b0, 1'b0, 1'b0, 1'b0);
    push(4'd4, 9'b011_000_000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i <= stall; i++) push(4'd5, 9'b011_010_000, 1'b0, 1'b0, 1'b0);
    push(4'd6, 9'b011_110_000, 1'b0, 1'b0, 1'b0);
    exp_cnt = exp_cnt + 4'd1;
    push_fetch();
    repeat (3 + stall) @(negedge clk);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_stur(input int stall);
    Op = OP_STUR; mem_ready = (stall == 0);
    push(4'd1, 9'b0, 1'b0, 1'b0, 1'b0);
    push(4'd4, 9'b110_000_000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i <= stall; i++) push(4'd7, 9'b110_001_000, 1'b0, 1'b0, 1'b0);
    exp_cnt = exp_cnt + 4'd1;
    push_fetch();
    repeat (3 + stall) @(negedge clk);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
  endtask

  task automatic run_cbz(input logic [10:0] op, input logic z, input logic mr);
    Op = op; Zero = z; mem_ready = mr;
    push(4'd1, 9'b0, 1'b0, 1'b0, 1'b0);
    push(4'd8, 9'b100_000_101, 1'b0, z, 1'b0);
    exp_cnt = exp_cnt + 4'd1;
    push_fetch();
    repeat (3) @(negedge clk);
    Zero = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic run_illegal(input logic [10:0] op);
    Op = op; mem_ready = 1'b0;
    push(4'd1, 9'b0, 1'b0, 1'b0, 1'b0);
`ifdef ILLEGAL_TRAP_EN
    for (int i = 0; i < 10; i++) push(4'd9, 9'b0, 1'b0, 1'b0, 1'b1);
    repeat (11) @(negedge clk);
    reset = 1'b1;
    exp_cnt = 4'd0;
    push_fetch();
    @(negedge clk);
    reset = 1'b0;
`else
    push_fetch();
    repeat (2) @(negedge clk);
`endif
  endtask

  task automatic run_reset_in_stall();
    Op = OP_LDUR; mem_ready = 1'b0;
    push(4'd1, 9'b0, 1'b0, 1'b0, 1'b0);
    push(4'd4, 9'b011_000_000, 1'b0, 1'b0, 1'b0);
    push(4'd5, 9'b011_010_000, 1'b0, 1'b0, 1'b0);
    push(4'd5, 9'b011_010_000, 1'b0, 1'b0, 1'b0);
    exp_cnt = 4'd0;
    push_fetch();
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    push_fetch();
    @(negedge clk);
    reset = 1'b0;

    run_r(OP_ADD);
    run_ldur(3);
    run_stur(0);
    run_stur(2);
    run_cbz(11'b101_1010_0101, 1'b1, 1'b0);
    run_cbz(11'b101_1010_0101, 1'b0, 1'b0);
    run_r(OP_SUB);
    run_r(OP_AND);
    run_r(OP_ORR);
    run_ldur(0);
    run_cbz(11'b101_1010_0111, 1'b1, 1'b1);
    run_illegal(11'b000_0000_0000);
    run_r(OP_ADD);
    run_reset_in_stall();
    for (int i = 0; i < 16; i++) run_cbz(11'b101_1010_0000, i[0], 1'b0);

    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
